// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: divider defaults, byte width, frame bit indices and FSM encoding.
// Frame layout depends on the UART_TX_PARITY_EN build option.
package uart_tx_pkg;

    localparam int unsigned DIV_RATE_DEF  = 260;
    localparam int unsigned DIV_CNT_W_DEF = 9;
    localparam int unsigned BYTE_W        = 8;

    localparam logic [3:0] BIT_START = 4'd0;
    localparam logic [3:0] BIT_DATA0 = 4'd1;
`ifdef UART_TX_PARITY_EN
    localparam logic [3:0] BIT_PARITY = 4'd9;
    localparam logic [3:0] BIT_STOP   = 4'd10;
`else
    localparam logic [3:0] BIT_STOP   = 4'd9;
`endif
    localparam logic [3:0] FRAME_LEN = BIT_STOP + 4'd1;

    typedef enum logic {
        StIdle = 1'b0,
        StSend = 1'b1
    } state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Command/status bundle between the UART controller (master) and the transmitter (slave).
interface uart_tx_if;
    import uart_tx_pkg::*;

    logic              tx_start;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_busy;
    logic              tx_end;
    logic              tx;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_busy,
        input  tx_end,
        input  tx
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_busy,
        output tx_end,
        output tx
    );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to insert the parity bit (11-bit frame).
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned DIV_RATE  = DIV_RATE_DEF,
    parameter int unsigned DIV_CNT_W = DIV_CNT_W_DEF
) (
    input  logic     clk,
    input  logic     reset,
    uart_tx_if.slave bus
);

    localparam logic [DIV_CNT_W-1:0] DivLast = DIV_CNT_W'(DIV_RATE - 1);
    localparam logic [3:0] DataLast = BIT_DATA0 + 4'(BYTE_W - 1);

    state_e               state_q, state_d;
    logic [DIV_CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]    shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 end_q, end_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        end_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (bus.tx_start) begin
                    state_d   = StSend;
                    shift_d   = bus.tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^bus.tx_data;
`endif
                    div_cnt_d = '0;
                    bit_cnt_d = BIT_START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            StSend: begin
                if (div_cnt_q != DivLast) begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end else begin
                    div_cnt_d = '0;
                    if (bit_cnt_q >= BIT_STOP) begin
                        // Saturate the bit counter so it never wraps back into the frame.
                        state_d   = StIdle;
                        busy_d    = 1'b0;
                        end_d     = 1'b1;
                        tx_d      = 1'b1;
                        bit_cnt_d = FRAME_LEN;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_d <= DataLast) begin
                            tx_d    = shift_q[0];
                            shift_d = shift_q >> 1;
`ifdef UART_TX_PARITY_EN
                        end else if (bit_cnt_d == BIT_PARITY) begin
                            tx_d = parity_q;
`endif
                        end else begin
                            tx_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            end_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            end_q     <= end_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_end  = end_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx (DIV_RATE=4): frame-level model checked every cycle plus
// hand-computed line literals, busy lengths and tx_end spacing.
module tb_uart_tx;

    localparam int D = 4;
`ifdef UART_TX_PARITY_EN
    localparam int L        = 11;
    localparam int BUSY_LEN = 44;
    localparam int SEP      = 45;
    localparam logic [10:0] LIT_A3 = 11'b1_0_10100011_0;
    localparam logic [10:0] LIT_3C = 11'b1_0_00111100_0;
    localparam logic [10:0] LIT_07 = 11'b1_1_00000111_0;
    localparam logic [10:0] LIT_03 = 11'b1_0_00000011_0;
`else
    localparam int L        = 10;
    localparam int BUSY_LEN = 40;
    localparam int SEP      = 41;
    localparam logic [10:0] LIT_A3 = 11'b0_1_10100011_0;
    localparam logic [10:0] LIT_3C = 11'b0_1_00111100_0;
    localparam logic [10:0] LIT_07 = 11'b0_1_00000111_0;
    localparam logic [10:0] LIT_03 = 11'b0_1_00000011_0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    uart_tx_if bus ();

    uart_tx #(
        .DIV_RATE (D),
        .DIV_CNT_W(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int end_cnt = 0;
    int end_prev = -1;
    int end_last = -1;
    int run = 0;
    int last_run = 0;
    int k = -1;  // position inside the expected frame, -1 when idle
    logic bits_m [0:10];

    // Model: a frame is L line bits each held D cycles, then one idle cycle with tx_end.
    initial begin : monitor
        logic e_tx, e_busy, e_end;
        int idx;
        @(posedge clk);
        forever begin
            @(negedge clk);
            cyc++;
            e_busy = (k >= 0) && (k < L * D);
            e_end  = (k == L * D);
            idx    = e_busy ? k / D : 0;
            e_tx   = e_busy ? bits_m[idx] : 1'b1;
            n_vec++;
            if (bus.tx !== e_tx || bus.tx_busy !== e_busy || bus.tx_end !== e_end) begin
                n_err++;
                $display("FAIL line cycle %0d: got tx=%b busy=%b end=%b, want tx=%b busy=%b end=%b",
                         cyc, bus.tx, bus.tx_busy, bus.tx_end, e_tx, e_busy, e_end);
            end
            if (bus.tx_end === 1'b1) begin
                end_cnt++;
                end_prev = end_last;
                end_last = cyc;
            end
            if (bus.tx_busy === 1'b1) run++;
            else if (run > 0) begin
                last_run = run;
                run = 0;
            end
            if (reset) k = -1;
            else if (bus.tx_start && !e_busy) begin
                k = 0;
                bits_m[0] = 1'b0;
                for (int i = 0; i < 8; i++) bits_m[1 + i] = bus.tx_data[i];
                bits_m[9] = ^bus.tx_data;
                bits_m[L - 1] = 1'b1;
            end else if (k >= 0 && k < L * D) k++;
            else k = -1;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.tx_start = 1'b1;
        bus.tx_data  = b;
        cycle();
        bus.tx_start = 1'b0;
        bus.tx_data  = ~b;
    endtask

    task automatic wait_end(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (bus.tx_end === 1'b1) seen = 1'b1;
            else cycle();
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s: got no tx_end within 200 cycles, want one", name);
        end
    endtask

    task automatic check_frame(input string name, input logic [7:0] b, input logic [10:0] lit);
        send(b);
        for (int i = 0; i < L; i++) begin
            n_vec++;
            if (bus.tx !== lit[i]) begin
                n_err++;
                $display("FAIL %s bit %0d: got %b want %b", name, i, bus.tx, lit[i]);
            end
            repeat (D) cycle();
        end
        repeat (2) cycle();
    endtask

    initial begin : stim
        int e0;
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) cycle();
        chk("idle_tx", bus.tx, 1);
        chk("idle_end_count", end_cnt, 0);

        check_frame("a3", 8'hA3, LIT_A3);
        chk("a3_busy_len", last_run, BUSY_LEN);
        chk("a3_end_count", end_cnt, 1);

        // Second request mid-frame must not disturb the 0x55 frame.
        e0 = end_cnt;
        send(8'h55);
        repeat (9) cycle();
        send(8'hFF);
        chk("ignore_bit2", bus.tx, 0);
        wait_end("ignore_end");
        repeat (5) cycle();
        chk("ignore_end_count", end_cnt - e0, 1);

        // Start accepted in the tx_end cycle; the tx_end cycle itself is idle line time.
        send(8'h80);
        wait_end("b2b_first_end");
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'h01;
        cycle();
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'hFE;
        chk("b2b_start_bit", bus.tx, 0);
        chk("b2b_busy", bus.tx_busy, 1);
        wait_end("b2b_second_end");
        cycle();
        chk("b2b_end_sep", end_last - end_prev, SEP);

        e0 = end_cnt;
        repeat (3) cycle();
        send(8'h00);
        repeat (16) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("abort_tx", bus.tx, 1);
        chk("abort_busy", bus.tx_busy, 0);
        repeat (50) cycle();
        chk("abort_no_end", end_cnt - e0, 0);
        check_frame("3c", 8'h3C, LIT_3C);
        chk("3c_end_count", end_cnt - e0, 1);

        check_frame("07", 8'h07, LIT_07);
        chk("07_busy_len", last_run, BUSY_LEN);
        check_frame("03", 8'h03, LIT_03);
        repeat (5) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no completion by 100000 ns, want finish");
        $fatal(1);
    end

endmodule
